// File: rtl/mmu_job_arbiter.sv
// Round-robin front end that shares one matrix multiply unit between two requesters.
// Define MMU_SCHED_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC cycles with an error response.

module mmu_job_arbiter #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mmu_enable,
    output logic [DATA_W-1:0] mmu_matrixA,
    output logic [DATA_W-1:0] mmu_matrixB,
    input  logic [DATA_W-1:0] mmu_result,
    input  logic              mmu_listo,
    output logic              busy,
    output logic [CNT_W-1:0]  job_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mmu_job_arbiter: TIMEOUT_CYC must be in 1..255");
    end

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   res_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                owner;
    logic                last_grant;
    logic                err_q;
    logic                grant;
    logic                accept;
    logic                timeout_hit;

    // On a tie the requester that did not win last time gets the MMU.
    always_comb begin
        grant = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            grant = ~last_grant;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (req_valid != 2'b00);
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

`ifdef MMU_SCHED_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (state != WAIT) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A listo arriving in the final WAIT cycle still counts as success.
    always_comb begin
        timeout_hit = 1'b0;
        if ((state == WAIT) && !mmu_listo && (wait_cnt == 8'(TIMEOUT_CYC - 1))) begin
            timeout_hit = 1'b1;
        end
    end
`else
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mmu_listo || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a       <= '0;
            op_b       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            res_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                op_a       <= grant ? req1_a : req0_a;
                op_b       <= grant ? req1_b : req0_b;
                owner      <= grant;
                last_grant <= grant;
            end
            if ((state == WAIT) && mmu_listo) begin
                res_q <= mmu_result;
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
            if ((state == RESP) && !err_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rsp_valid   = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err     = (state == RESP) && err_q;
    assign rsp_data    = res_q;
    assign mmu_enable  = (state == ISSUE);
    assign mmu_matrixA = op_a;
    assign mmu_matrixB = op_b;
    assign busy        = (state != IDLE);
    assign job_count   = cnt_q;

endmodule
